vga_timing_gen: RTL and testbench

//  Raster timing generator and colour output stage for the VGA peripheral. It counts pixels and lines on

---
 rtl/vga_timing_if.sv | 20 ++
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 tb/tb_vga_timing_gen.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Pin-side bundle of the VGA timing generator: raster address out, colour back in, sync/colour to pins.
interface vga_timing_if;
    logic [7:0] COLOUR_IN;
    logic [9:0] addrh;
    logic [9:0] addrv;
    logic [7:0] cout;
    logic       hs;
    logic       vs;
    logic       frame_start;

    modport master (
        input  COLOUR_IN,
        output addrh, addrv, cout, hs, vs, frame_start
    );

    modport slave (
        output COLOUR_IN,
        input  addrh, addrv, cout, hs, vs, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters, publishes the current position, and registers delayed sync/blank
// together with the returned colour onto the VGA pins.
module vga_timing_gen #(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int DELAY    = 1
) (
    input logic         HCLK,
    input logic         HRESET,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Pipeline entry layout: [2]=blank, [1]=hs, [0]=vs
    localparam logic [2:0] IDLE_TRIPLE = 3'b111;

    logic [1:0]             div_cnt_q, div_cnt_d;
    logic [9:0]             h_cnt_q, h_cnt_d;
    logic [9:0]             v_cnt_q, v_cnt_d;
    logic                   start_q, start_d;
    logic [DELAY-1:0][2:0]  pipe_q, pipe_d;
    logic [7:0]             cout_q, cout_d;
    logic                   hs_q, hs_d;
    logic                   vs_q, vs_d;
    logic                   fs_q, fs_d;
    logic                   tick;
    logic [2:0]             raw;

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? 2'd0 : div_cnt_q + 2'd1;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        start_d   = start_q;
        pipe_d    = pipe_q;
        cout_d    = cout_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        fs_d      = 1'b0;

        raw[2] = (h_cnt_q >= H_ACT) | (v_cnt_q >= V_ACT);
        raw[1] = ~((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        raw[0] = ~((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));

        if (tick) begin
            start_d = 1'b0;
            hs_d    = pipe_q[DELAY-1][1];
            vs_d    = pipe_q[DELAY-1][0];
            cout_d  = pipe_q[DELAY-1][2] ? 8'h00 : vga.COLOUR_IN;
            if (start_q) begin
                // First tick after reset enters (0,0) without advancing; the pipeline
                // stays idle so position 0 is not emitted twice.
                h_cnt_d = 10'd0;
                v_cnt_d = 10'd0;
                fs_d    = 1'b1;
            end else begin
                pipe_d[0] = raw;
                for (int i = 1; i < DELAY; i++) pipe_d[i] = pipe_q[i-1];
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = 10'd0;
                    if (v_cnt_q == V_LAST) begin
                        v_cnt_d = 10'd0;
                        fs_d    = 1'b1;
                    end else begin
                        v_cnt_d = v_cnt_q + 10'd1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            div_cnt_q <= 2'd0;
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            start_q   <= 1'b1;
            pipe_q    <= {DELAY{IDLE_TRIPLE}};
            cout_q    <= 8'h00;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            start_q   <= start_d;
            pipe_q    <= pipe_d;
            cout_q    <= cout_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            fs_q      <= fs_d;
        end
    end

    assign vga.addrh       = h_cnt_q;
    assign vga.addrv       = v_cnt_q;
    assign vga.cout        = cout_q;
    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
    assign vga.frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing, PIX_DIV=1/DELAY=3 colour alignment, and a tiny
// raster for whole-frame vertical behaviour.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   ncmp = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    vga_timing_if ifa ();
    vga_timing_if ifb ();
    vga_timing_if ifc ();

    vga_timing_gen u_a (.HCLK(clk), .HRESET(rst_a), .vga(ifa));

    vga_timing_gen #(.PIX_DIV(1), .DELAY(3)) u_b (.HCLK(clk), .HRESET(rst_b), .vga(ifb));

    vga_timing_gen #(
        .PIX_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .DELAY(1)
    ) u_c (.HCLK(clk), .HRESET(rst_c), .vga(ifc));

    // Pixel source for DUT B: three registered stages, so the colour of pixel p returns 3 ticks later
    logic [2:0][7:0] src;
    always @(posedge clk) begin
        if (rst_b) src <= '0;
        else       src <= {src[1:0], ifb.addrh[7:0]};
    end
    assign ifb.COLOUR_IN = src[2];

    typedef struct {
        int         n;
        int         h;
        int         v;
        logic       hs;
        logic       vs;
        logic [7:0] c;
        logic       fs;
    } vec_t;
    vec_t va[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, hs_low, first_hs, e3n, fsn, vs_low, fs1, fs2, e_a5, e_c5;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifa.COLOUR_IN = 8'hE3;
        ifc.COLOUR_IN = 8'hE3;

        // n = tick index after reset release (tick 0 enters (0,0)); pins show position n-2
        va[0]  = '{0,   0,   0, 1'b1, 1'b1, 8'h00, 1'b1};
        va[1]  = '{1,   1,   0, 1'b1, 1'b1, 8'h00, 1'b0};
        va[2]  = '{2,   2,   0, 1'b1, 1'b1, 8'hE3, 1'b0};
        va[3]  = '{641, 641, 0, 1'b1, 1'b1, 8'hE3, 1'b0};
        va[4]  = '{642, 642, 0, 1'b1, 1'b1, 8'h00, 1'b0};
        va[5]  = '{657, 657, 0, 1'b1, 1'b1, 8'h00, 1'b0};
        va[6]  = '{658, 658, 0, 1'b0, 1'b1, 8'h00, 1'b0};
        va[7]  = '{753, 753, 0, 1'b0, 1'b1, 8'h00, 1'b0};
        va[8]  = '{754, 754, 0, 1'b1, 1'b1, 8'h00, 1'b0};
        va[9]  = '{799, 799, 0, 1'b1, 1'b1, 8'h00, 1'b0};
        va[10] = '{800, 0,   1, 1'b1, 1'b1, 8'h00, 1'b0};
        va[11] = '{801, 1,   1, 1'b1, 1'b1, 8'h00, 1'b0};
        va[12] = '{802, 2,   1, 1'b1, 1'b1, 8'hE3, 1'b0};

        repeat (3) step();
        chk("rst_addrh", 32'(ifa.addrh), 0);
        chk("rst_addrv", 32'(ifa.addrv), 0);
        chk("rst_hs", 32'(ifa.hs), 1);
        chk("rst_vs", 32'(ifa.vs), 1);
        chk("rst_cout", 32'(ifa.cout), 0);
        chk("rst_fs", 32'(ifa.frame_start), 0);

        rst_a = 1'b0;
        step(); e = 1;
        chk("c1_addrh", 32'(ifa.addrh), 0);
        chk("c1_fs", 32'(ifa.frame_start), 0);
        chk("c1_cout", 32'(ifa.cout), 0);

        hs_low = 0; first_hs = -1; e3n = 0; fsn = 0;
        for (int i = 0; i < 13; i++) begin
            while (e < 2 * va[i].n + 2) begin
                step(); e++;
                if (e < 1600) begin
                    if (ifa.hs === 1'b0) begin
                        hs_low++;
                        if (first_hs < 0) first_hs = e;
                    end
                    if (ifa.cout === 8'hE3) e3n++;
                    if (ifa.frame_start === 1'b1) fsn++;
                end
            end
            chk($sformatf("a%0d_addrh", va[i].n), 32'(ifa.addrh), 32'(va[i].h));
            chk($sformatf("a%0d_addrv", va[i].n), 32'(ifa.addrv), 32'(va[i].v));
            chk($sformatf("a%0d_hs", va[i].n), 32'(ifa.hs), 32'(va[i].hs));
            chk($sformatf("a%0d_vs", va[i].n), 32'(ifa.vs), 32'(va[i].vs));
            chk($sformatf("a%0d_cout", va[i].n), 32'(ifa.cout), 32'(va[i].c));
            chk($sformatf("a%0d_fs", va[i].n), 32'(ifa.frame_start), 32'(va[i].fs));
        end
        chk("a_hs_low_cycles", 32'(hs_low), 192);
        chk("a_hs_first_cycle", 32'(first_hs), 1318);
        chk("a_active_cycles", 32'(e3n), 1280);
        chk("a_fs_count", 32'(fsn), 1);

        // Mid-line reset at (300,1)
        while (e < 2202) begin step(); e++; end
        chk("mid_addrh", 32'(ifa.addrh), 300);
        chk("mid_addrv", 32'(ifa.addrv), 1);
        chk("mid_cout", 32'(ifa.cout), 32'hE3);
        rst_a = 1'b1; step(); rst_a = 1'b0;
        chk("mrst_addrh", 32'(ifa.addrh), 0);
        chk("mrst_addrv", 32'(ifa.addrv), 0);
        chk("mrst_hs", 32'(ifa.hs), 1);
        chk("mrst_vs", 32'(ifa.vs), 1);
        chk("mrst_cout", 32'(ifa.cout), 0);
        chk("mrst_fs", 32'(ifa.frame_start), 0);
        step(); chk("mrst_e1_fs", 32'(ifa.frame_start), 0);
        step(); chk("mrst_e2_fs", 32'(ifa.frame_start), 1);
        chk("mrst_e2_addrh", 32'(ifa.addrh), 0);
        step(); chk("mrst_e3_fs", 32'(ifa.frame_start), 0);
        step(); chk("mrst_e4_addrh", 32'(ifa.addrh), 1);
        step(); step(); chk("mrst_e6_cout", 32'(ifa.cout), 32'hE3);

        // PIX_DIV=1, DELAY=3: each pixel's own value reaches cout 4 cycles later
        rst_b = 1'b0;
        e_a5 = -1; e_c5 = -1;
        for (int n = 0; n <= 40; n++) begin
            step();
            chk($sformatf("b%0d_addrh", n), 32'(ifb.addrh), 32'(n));
            chk($sformatf("b%0d_cout", n), 32'(ifb.cout), (n >= 4) ? 32'(n - 4) : 32'd0);
            chk($sformatf("b%0d_fs", n), 32'(ifb.frame_start), (n == 0) ? 32'd1 : 32'd0);
            if (ifb.addrh === 10'd5 && e_a5 < 0) e_a5 = n;
            if (ifb.cout === 8'h05 && e_c5 < 0) e_c5 = n;
        end
        chk("b_05_latency", 32'(e_c5 - e_a5), 4);

        // Tiny raster 16x8 ticks, two frames: vertical sync, wrap, frame_start cadence
        rst_c = 1'b0;
        e = 0; fsn = 0; vs_low = 0; e3n = 0; fs1 = -1; fs2 = -1;
        while (e < 512) begin
            step(); e++;
            if (ifc.vs === 1'b0) vs_low++;
            if (ifc.cout === 8'hE3) e3n++;
            if (ifc.frame_start === 1'b1) begin
                fsn++;
                if (fs1 < 0) fs1 = e;
                else if (fs2 < 0) fs2 = e;
            end
            if (e == 256) begin
                chk("c_last_addrh", 32'(ifc.addrh), 15);
                chk("c_last_addrv", 32'(ifc.addrv), 7);
            end
            if (e == 258) begin
                chk("c_wrap_addrh", 32'(ifc.addrh), 0);
                chk("c_wrap_addrv", 32'(ifc.addrv), 0);
                chk("c_wrap_fs", 32'(ifc.frame_start), 1);
            end
        end
        chk("c_fs_count", 32'(fsn), 2);
        chk("c_fs_period", 32'(fs2 - fs1), 256);
        chk("c_vs_low_cycles", 32'(vs_low), 128);
        chk("c_active_cycles", 32'(e3n), 128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
